// File: rtl/condicionador_pkg.sv
// condicionador_pkg
// Shared types and constants for the button conditioning block.
//   estado_t       : per-channel debounce FSM state (2 bits)
//   JOGADAS_W      : width of the accepted-move counter
//   JOGADAS_MAX    : saturation value of the move counter
//   incrementa_sat : saturating increment of the move counter
package condicionador_pkg;

   typedef enum logic [1:0] {
      SOLTO            = 2'd0,
      CONFIRMA_PRESSAO = 2'd1,
      PRESSIONADO      = 2'd2,
      CONFIRMA_SOLTURA = 2'd3
   } estado_t;

   localparam int                   JOGADAS_W   = 8;
   localparam logic [JOGADAS_W-1:0] JOGADAS_MAX = 8'd255;

   function automatic logic [JOGADAS_W-1:0] incrementa_sat(input logic [JOGADAS_W-1:0] v);
      logic [JOGADAS_W-1:0] r;
      if (v == JOGADAS_MAX) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/condicionador_botoes_debounce_botao.sv
// debounce_botao
// One button channel: polarity normalisation, 2-flop synchroniser and a
// four-state debounce FSM with a stability counter.
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset
//   i_raw      : asynchronous raw button level
//   o_estavel  : debounced pressed level (1 = pressed)
//   o_evento   : high during the cycle whose edge accepts a press
module debounce_botao
   import condicionador_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int CNT_W           = 16,
   parameter bit ATIVO_BAIXO     = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_estavel,
   output logic o_evento
);

   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

   logic             w_p;
   logic             r_sync1;
   logic             r_sync2;
   estado_t          r_estado;
   estado_t          w_estado_prox;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_prox;

   // After this XOR, 1 always means "pressed".
   assign w_p = i_raw ^ ATIVO_BAIXO;

   // Synchroniser, FSM state and counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_estado <= SOLTO;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= w_p;
         r_sync2  <= r_sync1;
         r_estado <= w_estado_prox;
         r_cnt    <= w_cnt_prox;
      end
   end

   // Next-state, counter and press-event decode.
   always_comb begin
      w_estado_prox = r_estado;
      w_cnt_prox    = r_cnt;
      o_evento      = 1'b0;
      case (r_estado)
         SOLTO: begin
            if (r_sync2) begin
               w_estado_prox = CONFIRMA_PRESSAO;
               w_cnt_prox    = '0;
            end else begin
               w_estado_prox = SOLTO;
            end
         end
         CONFIRMA_PRESSAO: begin
            if (!r_sync2) begin
               w_estado_prox = SOLTO;
            end else if (r_cnt == CNT_FIM) begin
               w_estado_prox = PRESSIONADO;
               o_evento      = 1'b1;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         PRESSIONADO: begin
            if (!r_sync2) begin
               w_estado_prox = CONFIRMA_SOLTURA;
               w_cnt_prox    = '0;
            end else begin
               w_estado_prox = PRESSIONADO;
            end
         end
         CONFIRMA_SOLTURA: begin
            // A return to pressed here is bounce on release: no new event.
            if (r_sync2) begin
               w_estado_prox = PRESSIONADO;
            end else if (r_cnt == CNT_FIM) begin
               w_estado_prox = SOLTO;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         default: begin
            w_estado_prox = SOLTO;
            w_cnt_prox    = '0;
         end
      endcase
   end

   assign o_estavel = (r_estado == PRESSIONADO) || (r_estado == CONFIRMA_SOLTURA);

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes
// Debounces N_BOTOES raw buttons and emits one single-cycle pulse per press,
// plus a saturating count of accepted moves.
//   i_clk             : system clock
//   i_rst             : synchronous active-high reset
//   i_botoes_raw      : asynchronous raw button levels
//   i_habilita        : 1 = press pulses allowed (events are dropped otherwise)
//   i_limpa_jogadas   : synchronous clear of the move counter (beats increment)
//   o_botoes_pulso    : registered one-cycle press pulses
//   o_botoes_estavel  : debounced pressed level per channel
//   o_jogada          : OR of o_botoes_pulso
//   o_jogadas         : saturating accepted-move count
// Build option: define CONDICIONADOR_EXCLUSIVO_EN to accept a press only when
// no other channel is held, with the lowest index winning simultaneous events.
module condicionador_botoes
   import condicionador_pkg::*;
#(
   parameter int N_BOTOES        = 8,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int CNT_W           = 16,
   parameter bit ATIVO_BAIXO     = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N_BOTOES-1:0]  i_botoes_raw,
   input  logic                 i_habilita,
   input  logic                 i_limpa_jogadas,
   output logic [N_BOTOES-1:0]  o_botoes_pulso,
   output logic [N_BOTOES-1:0]  o_botoes_estavel,
   output logic                 o_jogada,
   output logic [JOGADAS_W-1:0] o_jogadas
);

   logic [N_BOTOES-1:0]  w_evento;
   logic [N_BOTOES-1:0]  w_estavel;
   logic [N_BOTOES-1:0]  w_aceito;
   logic [N_BOTOES-1:0]  r_pulso;
   logic [JOGADAS_W-1:0] r_jogadas;

   for (genvar k = 0; k < N_BOTOES; k++) begin : g_canal
      debounce_botao #(
         .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
         .CNT_W           (CNT_W),
         .ATIVO_BAIXO     (ATIVO_BAIXO)
      ) u_debounce (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_raw     (i_botoes_raw[k]),
         .o_estavel (w_estavel[k]),
         .o_evento  (w_evento[k])
      );
   end

`ifdef CONDICIONADOR_EXCLUSIVO_EN
   // Exclusive arbitration: grant only if no other channel is held, lowest index first.
   always_comb begin
      logic                w_concedido;
      logic [N_BOTOES-1:0] w_outros;
      w_aceito    = '0;
      w_concedido = 1'b0;
      for (int k = 0; k < N_BOTOES; k++) begin
         w_outros    = w_estavel;
         w_outros[k] = 1'b0;
         if (w_evento[k] && !w_concedido && (w_outros == '0)) begin
            w_aceito[k] = 1'b1;
            w_concedido = 1'b1;
         end else begin
            w_aceito[k] = 1'b0;
         end
      end
   end
`else
   // Independent channels: every event is a candidate pulse.
   always_comb begin
      w_aceito = w_evento;
   end
`endif

   // Pulse register; gating drops events while habilita is low.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pulso <= '0;
      end else begin
         r_pulso <= w_aceito & {N_BOTOES{i_habilita}};
      end
   end

   // Move counter: clear beats increment, simultaneous pulses count once.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_jogadas <= '0;
      end else if (i_limpa_jogadas) begin
         r_jogadas <= '0;
      end else if (o_jogada) begin
         r_jogadas <= incrementa_sat(r_jogadas);
      end else begin
         r_jogadas <= r_jogadas;
      end
   end

   assign o_botoes_pulso   = r_pulso;
   assign o_botoes_estavel = w_estavel;
   assign o_jogada         = |r_pulso;
   assign o_jogadas        = r_jogadas;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes
// Directed bench for condicionador_botoes with DEBOUNCE_CICLOS=4, active-low
// buttons. A per-cycle vector table covers a full press/release and a bounce;
// hand-written sequences cover habilita gating, saturation, clear priority,
// simultaneous presses and reset mid-press.
module tb_condicionador_botoes;

   logic       clk;
   logic       rst;
   logic [7:0] raw;
   logic       hab;
   logic       limpa;
   logic [7:0] pulso;
   logic [7:0] estavel;
   logic       jogada;
   logic [7:0] jogadas;

   int total;
   int bad;

   typedef struct {
      logic [7:0] raw;
      logic       hab;
      logic       limpa;
      logic       rst;
      logic [7:0] ep;
      logic [7:0] ee;
      logic [7:0] ej;
   } vec_t;

   vec_t tab[$];

   condicionador_botoes #(
      .N_BOTOES        (8),
      .DEBOUNCE_CICLOS (4),
      .CNT_W           (16),
      .ATIVO_BAIXO     (1'b1)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_botoes_raw     (raw),
      .i_habilita       (hab),
      .i_limpa_jogadas  (limpa),
      .o_botoes_pulso   (pulso),
      .o_botoes_estavel (estavel),
      .o_jogada         (jogada),
      .o_jogadas        (jogadas)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] r, input logic h, input logic l, input logic rs,
                      input logic [7:0] ep, input logic [7:0] ee, input logic [7:0] ej);
      vec_t v;
      v.raw = r; v.hab = h; v.limpa = l; v.rst = rs;
      v.ep = ep; v.ee = ee; v.ej = ej;
      tab.push_back(v);
   endtask

   // Press the buttons in mask, look for the pulse over 12 edges, then release.
   task automatic do_press(input logic [7:0] mask, input logic [7:0] exp, input string nm);
      int         first;
      int         n;
      logic [7:0] val;
      first = 0; n = 0; val = 8'h00;
      raw = ~mask;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (pulso != 8'h00) begin
            n++;
            if (first == 0) begin
               first = i;
               val   = pulso;
            end
         end
      end
      if (exp != 8'h00) begin
         chk({nm, " latency"}, first, 32'd7);
         chk({nm, " value"}, {24'd0, val}, {24'd0, exp});
         chk({nm, " count"}, n, 32'd1);
      end else begin
         chk({nm, " none"}, n, 32'd0);
      end
      raw = 8'hFF;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int first;
      total = 0; bad = 0;
      raw = 8'hFF; hab = 1'b1; limpa = 1'b0; rst = 1'b1;

      // Vector table: reset, press of button 2, hold, release, then bounce on button 0.
      add(8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'd0);
      add(8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'd0);
      for (int i = 1; i <= 6; i++) add(8'hFB, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0);
      add(8'hFB, 1'b1, 1'b0, 1'b0, 8'h04, 8'h04, 8'd0);
      add(8'hFB, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'd1);
      for (int i = 0; i < 12; i++) add(8'hFB, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'd1);
      for (int i = 0; i < 6; i++) add(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'd1);
      add(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1);
      for (int i = 0; i < 3; i++) add(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1);
      for (int i = 0; i < 3; i++) add(8'hFE, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1);
      add(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1);
      for (int i = 0; i < 2; i++) add(8'hFE, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1);
      for (int i = 0; i < 10; i++) add(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1);

      for (int i = 0; i < tab.size(); i++) begin
         raw = tab[i].raw; hab = tab[i].hab; limpa = tab[i].limpa; rst = tab[i].rst;
         tick();
         chk($sformatf("vec%0d pulso", i), {24'd0, pulso}, {24'd0, tab[i].ep});
         chk($sformatf("vec%0d estavel", i), {24'd0, estavel}, {24'd0, tab[i].ee});
         chk($sformatf("vec%0d jogada", i), {31'd0, jogada}, {31'd0, (tab[i].ep != 8'h00)});
         chk($sformatf("vec%0d jogadas", i), {24'd0, jogadas}, {24'd0, tab[i].ej});
      end

      // habilita low during the press: event dropped, not deferred.
      do_reset();
      chk("rst jogadas", {24'd0, jogadas}, 32'd0);
      hab = 1'b0;
      raw = ~8'h10;
      first = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (pulso != 8'h00) first++;
      end
      chk("hab0 estavel", {24'd0, estavel}, 32'h10);
      hab = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (pulso != 8'h00) first++;
      end
      chk("hab0 no pulse", first, 32'd0);
      raw = 8'hFF;
      for (int i = 0; i < 10; i++) tick();
      do_press(8'h10, 8'h10, "repress");
      chk("repress jogadas", {24'd0, jogadas}, 32'd1);

      // Saturation after 260 presses, then clear during a pulse.
      do_reset();
      for (int i = 0; i < 260; i++) do_press(8'h20, 8'h20, "sat");
      chk("sat jogadas", {24'd0, jogadas}, 32'd255);
      do_reset();
      raw = ~8'h20;
      for (int i = 0; i < 7; i++) tick();
      chk("limpa pulso", {24'd0, pulso}, 32'h20);
      limpa = 1'b1;
      tick();
      chk("limpa jogadas", {24'd0, jogadas}, 32'd0);
      limpa = 1'b0;
      tick();
      chk("limpa after", {24'd0, jogadas}, 32'd0);
      raw = 8'hFF;
      for (int i = 0; i < 10; i++) tick();

      // Buttons 1 and 6 together.
      do_reset();
`ifdef CONDICIONADOR_EXCLUSIVO_EN
      do_press(8'h42, 8'h02, "simul");
`else
      do_press(8'h42, 8'h42, "simul");
`endif
      chk("simul jogadas", {24'd0, jogadas}, 32'd1);

      // Reset while button 3 is in CONFIRMA_PRESSAO, button kept held.
      raw = ~8'h08;
      for (int i = 0; i < 4; i++) tick();
      chk("midpress estavel", {24'd0, estavel}, 32'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid pulso", {24'd0, pulso}, 32'h00);
      chk("rstmid estavel", {24'd0, estavel}, 32'h00);
      chk("rstmid jogadas", {24'd0, jogadas}, 32'd0);
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (pulso == 8'h08 && first == 0) first = i;
      end
      chk("rstmid latency", first, 32'd7);
      chk("rstmid jogadas1", {24'd0, jogadas}, 32'd1);
      raw = 8'hFF;
      for (int i = 0; i < 10; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Upstream stage of the LED-matrix puzzle datapath; sits between the board push-buttons and the matrix controller's `botoes[7:0]` input.
- Synchronises and debounces each raw button, then emits exactly one single-cycle press pulse per physical press.
- Keeps a saturating count of accepted moves for the UC/display.
- The matrix controller toggles LEDs on every cycle `botoes[k]`=1, so pulses must never exceed one cycle per press.

Parameters:
- N_BOTOES, 8, number of button channels.
- DEBOUNCE_CICLOS, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); must be ≥2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CICLOS.
- ATIVO_BAIXO, 1, 1 = raw buttons read 0 when pressed; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- botoes_raw  in  N_BOTOES  asynchronous raw button levels.
- habilita  in  1  from UC; 1 = pulses allowed.
- limpa_jogadas  in  1  synchronous clear of move counter.
- botoes_pulso  out  N_BOTOES  one-cycle press pulses to matrix controller.
- botoes_estavel  out  N_BOTOES  debounced pressed level (1 = pressed).
- jogada  out  1  OR of botoes_pulso, same cycle.
- jogadas  out  8  accepted-move count, saturating.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset state:
  - All synchroniser flops hold "not pressed".
  - All FSMs are in SOLTO; counters = 0.
  - botoes_pulso = 0, botoes_estavel = 0, jogada = 0, jogadas = 0.
- Input conditioning:
  - Polarity is normalised first: p = botoes_raw XOR {N{ATIVO_BAIXO}}.
  - p then passes through a 2-flop synchroniser, giving s.
- Per-channel FSM, state SOLTO:
  - s=1 → CONFIRMA_PRESSAO, counter ← 0.
- State CONFIRMA_PRESSAO:
  - s=0 → SOLTO.
  - s=1 and counter < DEBOUNCE_CICLOS-1 → counter+1.
  - s=1 and counter == DEBOUNCE_CICLOS-1 → PRESSIONADO, and the press event fires.
- State PRESSIONADO:
  - s=0 → CONFIRMA_SOLTURA, counter ← 0.
- State CONFIRMA_SOLTURA:
  - s=1 → PRESSIONADO, with no event.
  - s=0 and counter == DEBOUNCE_CICLOS-1 → SOLTO.
  - Otherwise counter+1.
- botoes_estavel[k] = 1 in PRESSIONADO and CONFIRMA_SOLTURA.
- Pulse timing:
  - botoes_pulso[k] is registered and high for exactly the one cycle after the event, only if habilita=1 on the event cycle.
  - Latency from the first clock edge sampling a stable pressed raw level to the pulse going high is DEBOUNCE_CICLOS+3 edges.
- habilita=0:
  - FSMs keep tracking, but events are dropped, not deferred.
  - A button already in PRESSIONADO when habilita rises produces no pulse until released and pressed again.
- Move counter:
  - jogadas increments by 1 in any cycle where jogada=1; multiple simultaneous pulses count as 1.
  - Saturates at 255.
  - limpa_jogadas=1 forces 0 and has priority over increment.
- Bounce:
  - Any glitch shorter than DEBOUNCE_CICLOS cycles on s produces no pulse and no change in botoes_estavel.
- Reset mid-press:
  - The channel returns to SOLTO.
  - A button still held after reset release generates a fresh pulse after the full latency.
- Simultaneous presses: without the optional feature, channels are fully independent and may pulse in the same cycle.

Optional Feature:
- Macro: CONDICIONADOR_EXCLUSIVO_EN.
- Defined:
  - A press event on channel k is accepted only if every other channel is in SOLTO or CONFIRMA_PRESSAO.
  - Of several events in the same cycle, only the lowest index pulses; the others enter PRESSIONADO silently.
  - botoes_pulso is therefore one-hot or zero.
- Undefined: independent channels as above.

Decomposition:
- Package condicionador_pkg holds:
  - FSM state enum (SOLTO, CONFIRMA_PRESSAO, PRESSIONADO, CONFIRMA_SOLTURA), 2-bit.
  - JOGADAS_W=8 and JOGADAS_MAX=255.
- Sub-module debounce_botao (synchroniser + FSM + counter for one channel, outputs estavel and evento):
  - Instantiated N_BOTOES times by generate.
  - The top level does habilita gating, exclusivity arbitration, pulse registers and the move counter.

Test Plan:
- DEBOUNCE_CICLOS=4, ATIVO_BAIXO=1, habilita=1; botoes_raw[2] 1→0 held 20 cycles → botoes_pulso=8'b00000100 for exactly 1 cycle, 7 edges after first low sample; jogadas=1; botoes_estavel[2]=1 until release is confirmed.
- Raw[0] bounces low 3 cycles, high 1, low 2, then high → no pulse; jogadas stays 0; botoes_estavel[0] never 1.
- Held press with habilita=0, then habilita raised while still held → no pulse. Release, re-press → one pulse; jogadas=1.
- 260 separate presses on button 5 → jogadas=255 (saturated). Then limpa_jogadas asserted in the same cycle as a pulse → jogadas=0.
- Buttons 1 and 6 pressed in the same cycle:
  - Without macro → botoes_pulso=8'b01000010 for 1 cycle; jogadas+1.
  - With CONDICIONADOR_EXCLUSIVO_EN → 8'b00000010.
- rst asserted for 1 cycle during CONFIRMA_PRESSAO of button 3, button kept held → outputs 0 at next edge; pulse appears 7 edges after rst deasserts.
